// File: rtl/coherent_average_ctrl.sv
// Coherent-average sequencer: aligns to the frame sync, walks the accumulator
// address over every point of every frame, then streams the averaged buffer out.
module coherent_average_ctrl #(
    parameter int POINTS_LOG2 = 7,
    parameter int FRAMES_LOG2 = 13,
    parameter int RESYNC      = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   in_valid,
    input  logic                   sync_in,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   acc_we,
    output logic                   acc_first,
    output logic [POINTS_LOG2-1:0] acc_addr,
    output logic                   rd_en,
    output logic [POINTS_LOG2-1:0] rd_addr,
    output logic                   out_valid,
    output logic                   out_last,
    output logic [FRAMES_LOG2-1:0] frame_cnt,
    output logic                   sync_err
);

    localparam logic [POINTS_LOG2-1:0] LAST_POINT = '1;
    localparam logic [FRAMES_LOG2-1:0] LAST_FRAME = '1;
    localparam logic [POINTS_LOG2-1:0] PT_ONE     = POINTS_LOG2'(1);
    localparam logic [FRAMES_LOG2-1:0] FR_ONE     = FRAMES_LOG2'(1);
    localparam logic [POINTS_LOG2:0]   RD_ONE     = (POINTS_LOG2 + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SYNC,
        ACCUM,
        READOUT,
        DONE
    } state_t;

    state_t                 state_q;
    logic                   en_q;
    logic                   en_prev_q;
    logic [POINTS_LOG2-1:0] point_cnt_q;
    logic [FRAMES_LOG2-1:0] frame_cnt_q;
    logic [POINTS_LOG2:0]   rd_cnt_q;
    logic                   sync_err_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   acc_we_q;
    logic                   acc_first_q;
    logic [POINTS_LOG2-1:0] acc_addr_q;
    logic                   rd_en_q;
    logic [POINTS_LOG2-1:0] rd_addr_q;
    logic                   out_valid_q;
    logic                   out_last_q;

    logic en_rise;
    logic sample_ok;
    logic frame_end;
    logic last_frame;

    assign en_rise    = en_q && !en_prev_q;
    // The sync sample itself is point 0 of the frame, so it is accepted in WAIT_SYNC.
    assign sample_ok  = in_valid && ((state_q == ACCUM) || (state_q == WAIT_SYNC && sync_in));
    assign frame_end  = (point_cnt_q == LAST_POINT);
    assign last_frame = (frame_cnt_q == LAST_FRAME);

    // NOTE: sequential state uses non-blocking assignments only; the strobe
    // defaults at the top of the clocked branch make every strobe a one-cycle pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            en_q        <= 1'b0;
            en_prev_q   <= 1'b0;
            point_cnt_q <= '0;
            frame_cnt_q <= '0;
            rd_cnt_q    <= '0;
            sync_err_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            acc_we_q    <= 1'b0;
            acc_first_q <= 1'b0;
            acc_addr_q  <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            en_q        <= enable;
            en_prev_q   <= en_q;
            acc_we_q    <= 1'b0;
            acc_first_q <= 1'b0;
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (en_rise) begin
                        point_cnt_q <= '0;
                        frame_cnt_q <= '0;
                        rd_cnt_q    <= '0;
                        sync_err_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= WAIT_SYNC;
                    end
                end

                WAIT_SYNC, ACCUM: begin
                    if (!enable) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (sample_ok) begin
                        acc_we_q    <= 1'b1;
                        acc_addr_q  <= point_cnt_q;
                        acc_first_q <= (frame_cnt_q == '0);
                        point_cnt_q <= point_cnt_q + PT_ONE;
                        if (state_q == ACCUM && sync_in && point_cnt_q != '0) begin
                            sync_err_q <= 1'b1;
                        end
                        if (frame_end) begin
                            frame_cnt_q <= frame_cnt_q + FR_ONE;
                            if (last_frame) begin
                                rd_cnt_q <= '0;
                                state_q  <= READOUT;
                            end else if (RESYNC != 0) begin
                                state_q <= WAIT_SYNC;
                            end else begin
                                state_q <= ACCUM;
                            end
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end

                READOUT: begin
                    if (!enable) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        out_valid_q <= rd_en_q;
                        out_last_q  <= rd_en_q && (rd_addr_q == LAST_POINT);
                        // rd_cnt_q's top bit marks that every point has been issued.
                        if (out_last_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (out_ready && !rd_cnt_q[POINTS_LOG2]) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= rd_cnt_q[POINTS_LOG2-1:0];
                            rd_cnt_q  <= rd_cnt_q + RD_ONE;
                        end
                    end
                end

                DONE: begin
                    if (!enable) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign acc_we    = acc_we_q;
    assign acc_first = acc_first_q;
    assign acc_addr  = acc_addr_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign frame_cnt = frame_cnt_q;
    assign sync_err  = sync_err_q;

endmodule
